fft_mdc_stage: RTL and testbench

FFT_MDC_STAGE -- requirements
Module: fft_mdc_stage

---
 rtl/fft_mdc_stage.sv | 172 +++++++++++++++++
 tb/tb_fft_mdc_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mdc_stage.sv
// rtl/fft_mdc_stage.sv - radix-2 multi-path delay commutator FFT stage
module fft_mdc_stage #(
    parameter int WIDTH   = 9,
    parameter int DELAY   = 8,
    parameter int TW_FRAC = 7,
    parameter int SCALE   = 0,
    parameter int MUL_EN  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sync_clr,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] inUp_re,
    input  logic signed [WIDTH-1:0] inUp_im,
    input  logic signed [WIDTH-1:0] inL_re,
    input  logic signed [WIDTH-1:0] inL_im,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] outUp_re,
    output logic signed [WIDTH-1:0] outUp_im,
    output logic signed [WIDTH-1:0] outL_re,
    output logic signed [WIDTH-1:0] outL_im
);
    localparam int CW  = $clog2(2 * DELAY);
    localparam int TWW = TW_FRAC + 2;
    localparam int PW  = WIDTH + TWW + 1;

    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH:0]   ONE_W = {{WIDTH{1'b0}}, 1'b1};
    localparam logic signed [PW-1:0]    RND   = PW'(1) <<< (TW_FRAC - 1);

    // Twiddle W_(2*DELAY)^k = cos(pi*k/DELAY) - j*sin(pi*k/DELAY), rounded to nearest
    function automatic logic signed [TWW-1:0] f_tw(input int k, input bit im);
        real ang;
        real v;
        int  q;
        ang = 3.14159265358979323846 * real'(k) / real'(DELAY);
        v   = (im ? -$sin(ang) : $cos(ang)) * (2.0 ** TW_FRAC);
        q   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return TWW'(q);
    endfunction

    // Butterfly sum/difference back to WIDTH: halve with rounding or saturate
    function automatic logic signed [WIDTH-1:0] f_reduce(input logic signed [WIDTH:0] x);
        if (SCALE != 0)
            f_reduce = WIDTH'((x + ONE_W) >>> 1);
        else if (x[WIDTH] != x[WIDTH-1])
            f_reduce = x[WIDTH] ? S_MIN : S_MAX;
        else
            f_reduce = WIDTH'(x);
    endfunction

    // Saturate a rounded, shifted product to WIDTH
    function automatic logic signed [WIDTH-1:0] f_sat_p(input logic signed [PW-1:0] x);
        if ((x[PW-1:WIDTH-1] == '0) || (x[PW-1:WIDTH-1] == '1))
            f_sat_p = WIDTH'(x);
        else
            f_sat_p = x[PW-1] ? S_MIN : S_MAX;
    endfunction

    logic [CW-1:0] r_cnt;
    logic          r_primed;
    logic signed [WIDTH-1:0] r_dl1_re [DELAY];
    logic signed [WIDTH-1:0] r_dl1_im [DELAY];
    logic signed [WIDTH-1:0] r_dl2_re [DELAY];
    logic signed [WIDTH-1:0] r_dl2_im [DELAY];
    logic signed [TWW-1:0]   w_rom_re [DELAY];
    logic signed [TWW-1:0]   w_rom_im [DELAY];

    logic            w_accept;
    logic            w_p;
    logic [CW-2:0]   w_k;
    logic signed [WIDTH-1:0] w_dl2_in_re, w_dl2_in_im;
    logic signed [WIDTH-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [WIDTH:0]   w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic signed [WIDTH-1:0] w_s_re, w_s_im, w_d_re, w_d_im;
    logic signed [TWW-1:0]   w_wr, w_wi;
    logic signed [PW-1:0]    w_pr, w_pi;
    logic signed [WIDTH-1:0] w_m_re, w_m_im;
    logic signed [WIDTH-1:0] w_up_re, w_up_im, w_l_re, w_l_im;

    for (genvar g = 0; g < DELAY; g++) begin : g_rom
        assign w_rom_re[g] = f_tw(g, 1'b0);
        assign w_rom_im[g] = f_tw(g, 1'b1);
    end

    assign w_accept = in_valid & ~sync_clr;
    assign w_p      = r_cnt[CW-1];
    assign w_k      = r_cnt[CW-2:0];

    // Commutator: phase 0 routes the upper input into delay line 2, phase 1 swaps
    assign w_dl2_in_re = w_p ? r_dl1_re[DELAY-1] : inUp_re;
    assign w_dl2_in_im = w_p ? r_dl1_im[DELAY-1] : inUp_im;
    assign w_b_re      = w_p ? inUp_re : r_dl1_re[DELAY-1];
    assign w_b_im      = w_p ? inUp_im : r_dl1_im[DELAY-1];
    assign w_a_re      = r_dl2_re[DELAY-1];
    assign w_a_im      = r_dl2_im[DELAY-1];

    assign w_sum_re = {w_a_re[WIDTH-1], w_a_re} + {w_b_re[WIDTH-1], w_b_re};
    assign w_sum_im = {w_a_im[WIDTH-1], w_a_im} + {w_b_im[WIDTH-1], w_b_im};
    assign w_dif_re = {w_a_re[WIDTH-1], w_a_re} - {w_b_re[WIDTH-1], w_b_re};
    assign w_dif_im = {w_a_im[WIDTH-1], w_a_im} - {w_b_im[WIDTH-1], w_b_im};
    assign w_s_re   = f_reduce(w_sum_re);
    assign w_s_im   = f_reduce(w_sum_im);
    assign w_d_re   = f_reduce(w_dif_re);
    assign w_d_im   = f_reduce(w_dif_im);

    assign w_wr = w_rom_re[w_k];
    assign w_wi = w_rom_im[w_k];
    assign w_pr = PW'(w_d_re) * PW'(w_wr) - PW'(w_d_im) * PW'(w_wi) + RND;
    assign w_pi = PW'(w_d_re) * PW'(w_wi) + PW'(w_d_im) * PW'(w_wr) + RND;
    assign w_m_re = (MUL_EN != 0) ? f_sat_p(w_pr >>> TW_FRAC) : w_d_re;
    assign w_m_im = (MUL_EN != 0) ? f_sat_p(w_pi >>> TW_FRAC) : w_d_im;

    assign w_up_re = w_p ? w_s_re : w_a_re;
    assign w_up_im = w_p ? w_s_im : w_a_im;
    assign w_l_re  = w_p ? w_m_re : w_b_re;
    assign w_l_im  = w_p ? w_m_im : w_b_im;

    // Delay lines shift only on accepted samples so input gaps stall without loss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                r_dl1_re[i] <= '0;
                r_dl1_im[i] <= '0;
                r_dl2_re[i] <= '0;
                r_dl2_im[i] <= '0;
            end
        end else if (w_accept) begin
            r_dl1_re[0] <= inL_re;
            r_dl1_im[0] <= inL_im;
            r_dl2_re[0] <= w_dl2_in_re;
            r_dl2_im[0] <= w_dl2_in_im;
            for (int i = 1; i < DELAY; i++) begin
                r_dl1_re[i] <= r_dl1_re[i-1];
                r_dl1_im[i] <= r_dl1_im[i-1];
                r_dl2_re[i] <= r_dl2_re[i-1];
                r_dl2_im[i] <= r_dl2_im[i-1];
            end
        end
    end

    // Sample counter, priming flag and registered outputs; frame restart wins over data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_primed  <= 1'b0;
            out_valid <= 1'b0;
            outUp_re  <= '0;
            outUp_im  <= '0;
            outL_re   <= '0;
            outL_im   <= '0;
        end else if (sync_clr) begin
            r_cnt     <= '0;
            r_primed  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid & r_primed;
            if (in_valid) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == '1)
                    r_primed <= 1'b1;
                if (r_primed) begin
                    outUp_re <= w_up_re;
                    outUp_im <= w_up_im;
                    outL_re  <= w_l_re;
                    outL_im  <= w_l_im;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_mdc_stage.sv
// tb/tb_fft_mdc_stage.sv - self-checking bench for fft_mdc_stage
module tb_fft_mdc_stage;
    localparam int D  = 8;
    localparam int N2 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync_clr = 1'b0;
    logic in_valid = 1'b0;
    logic signed [8:0] u_re = '0, u_im = '0, l_re = '0, l_im = '0;
    logic              ov  [3];
    logic signed [8:0] our [3];
    logic signed [8:0] oui [3];
    logic signed [8:0] olr [3];
    logic signed [8:0] oli [3];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fft_mdc_stage dut0 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid),
        .inUp_re(u_re), .inUp_im(u_im), .inL_re(l_re), .inL_im(l_im),
        .out_valid(ov[0]), .outUp_re(our[0]), .outUp_im(oui[0]), .outL_re(olr[0]), .outL_im(oli[0]));
    fft_mdc_stage #(.SCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid),
        .inUp_re(u_re), .inUp_im(u_im), .inL_re(l_re), .inL_im(l_im),
        .out_valid(ov[1]), .outUp_re(our[1]), .outUp_im(oui[1]), .outL_re(olr[1]), .outL_im(oli[1]));
    fft_mdc_stage #(.MUL_EN(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid),
        .inUp_re(u_re), .inUp_im(u_im), .inL_re(l_re), .inL_im(l_im),
        .out_valid(ov[2]), .outUp_re(our[2]), .outUp_im(oui[2]), .outL_re(olr[2]), .outL_im(oli[2]));

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int hu_re [1024], hu_im [1024], hl_re [1024], hl_im [1024];
    int h, nclr;
    bit ev;
    int eur [3], eui [3], elr [3], eli [3];
    int twr [D], twi [D];

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction
    function automatic int clamp(input int x);
        return (x > 255) ? 255 : ((x < -256) ? -256 : x);
    endfunction
    function automatic int red(input int x, input bit sc);
        return sc ? ((x + 1) >>> 1) : clamp(x);
    endfunction

    initial begin
        for (int k = 0; k < D; k++) begin
            twr[k] = rnd(128.0 * $cos(3.14159265358979 * k / D));
            twi[k] = rnd(-128.0 * $sin(3.14159265358979 * k / D));
        end
        h = 0; nclr = 0; ev = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                h = 0; nclr = 0; ev = 0;
                for (int j = 0; j < 3; j++) begin eur[j] = 0; eui[j] = 0; elr[j] = 0; eli[j] = 0; end
            end else if (sync_clr) begin
                nclr = 0; ev = 0;
            end else if (in_valid) begin
                hu_re[h] = u_re; hu_im[h] = u_im; hl_re[h] = l_re; hl_im[h] = l_im;
                ev = (nclr >= N2);
                if (ev) begin
                    int c, k, dr, di;
                    c = nclr % N2;
                    k = c % D;
                    for (int j = 0; j < 3; j++) begin
                        if (c >= D) begin
                            eur[j] = red(hu_re[h-D] + hu_re[h], j == 1);
                            eui[j] = red(hu_im[h-D] + hu_im[h], j == 1);
                            dr = red(hu_re[h-D] - hu_re[h], j == 1);
                            di = red(hu_im[h-D] - hu_im[h], j == 1);
                            if (j != 2) begin
                                elr[j] = clamp((dr * twr[k] - di * twi[k] + 64) >>> 7);
                                eli[j] = clamp((dr * twi[k] + di * twr[k] + 64) >>> 7);
                            end else begin
                                elr[j] = dr; eli[j] = di;
                            end
                        end else begin
                            eur[j] = hl_re[h-N2]; eui[j] = hl_im[h-N2];
                            elr[j] = hl_re[h-D];  eli[j] = hl_im[h-D];
                        end
                    end
                end
                h++; nclr++;
            end else begin
                ev = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit rec_en = 0;
    logic [35:0] rec_q [$];
    logic [35:0] ref_q [$];

    initial forever begin
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("cyc_valid dut%0d", j), int'(ov[j]), int'(ev));
            chk($sformatf("cyc_up_re dut%0d", j), our[j], eur[j]);
            chk($sformatf("cyc_up_im dut%0d", j), oui[j], eui[j]);
            chk($sformatf("cyc_l_re dut%0d", j),  olr[j], elr[j]);
            chk($sformatf("cyc_l_im dut%0d", j),  oli[j], eli[j]);
        end
        if (rec_en && ov[0]) rec_q.push_back({our[0], oui[0], olr[0], oli[0]});
    end

    // ---------------- stimulus ----------------
    function automatic int rv(input int i, input int s);
        return ((i * 37 + s * 53 + 11) % 511) - 255;
    endfunction

    task automatic send(input int ur, input int ui, input int lr, input int li, input bit clr);
        u_re = 9'(ur); u_im = 9'(ui); l_re = 9'(lr); l_im = 9'(li);
        in_valid = 1'b1; sync_clr = clr;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; sync_clr = 1'b0;
    endtask

    task automatic send_ramp(input int i);
        send(rv(i, 0), rv(i, 1), rv(i, 2), rv(i, 3), 1'b0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (4) begin
            u_re = 9'($urandom); u_im = 9'($urandom); l_re = 9'($urandom); l_im = 9'($urandom);
            in_valid = 1'($urandom); sync_clr = 1'($urandom);
            @(negedge clk);
            chk("rst_valid", int'(ov[0]), 0);
            chk("rst_up_re", our[0], 0);
            chk("rst_l_im", oli[0], 0);
        end
        in_valid = 1'b0; sync_clr = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        // reset with toggling inputs, then priming
        do_reset();
        for (int i = 0; i < N2; i++) begin
            send_ramp(i);
            chk("prime_valid", int'(ov[0]), 0);
        end
        send_ramp(N2);
        chk("primed_valid", int'(ov[0]), 1);
        idle(2);

        // DC stream
        do_reset();
        for (int i = 0; i < 48; i++) begin
            send(100, 0, 100, 0, 1'b0);
            if (i >= N2) begin
                chk("dc_up_re", our[0], ((i % N2) >= D) ? 200 : 100);
                chk("dc_up_im", oui[0], 0);
                chk("dc_l_re", olr[0], ((i % N2) >= D) ? 0 : 100);
            end
        end
        idle(2);

        // gap-free versus stalled stream
        do_reset();
        rec_q.delete(); rec_en = 1;
        for (int i = 0; i < 48; i++) send_ramp(i);
        idle(2);
        ref_q = rec_q;
        do_reset();
        rec_q.delete();
        for (int i = 0; i < 48; i++) begin
            send_ramp(i);
            idle($urandom_range(1, 5));
        end
        idle(2);
        rec_en = 0;
        chk("stall_ref_count", ref_q.size(), 32);
        chk("stall_count", rec_q.size(), 32);
        begin
            int nd = 0;
            for (int i = 0; i < 32 && i < rec_q.size() && i < ref_q.size(); i++)
                if (rec_q[i] != ref_q[i]) nd++;
            chk("stall_seq_diffs", nd, 0);
        end

        // saturation
        do_reset();
        for (int i = 0; i < 32; i++) begin
            send(255, 255, 255, 255, 1'b0);
            if (i >= N2) begin
                chk("sat_up_re s0", our[0], 255);
                chk("sat_up_im s0", oui[0], 255);
                chk("sat_up_re s1", our[1], 255);
                chk("sat_up_im s1", oui[1], 255);
            end
        end
        idle(2);

        // twiddle at k = DELAY/2
        do_reset();
        for (int i = 0; i < 32; i++) begin
            send(((i % N2) == 4) ? 64 : 0, 0, 0, 0, 1'b0);
            if (i == 28) begin
                chk("tw_l_re mul", olr[0], 0);
                chk("tw_l_im mul", oli[0], -64);
                chk("tw_l_re bypass", olr[2], 64);
                chk("tw_l_im bypass", oli[2], 0);
            end
        end
        idle(2);

        // sync_clr at accepted sample 20
        do_reset();
        for (int i = 0; i < 20; i++) send_ramp(i);
        send(rv(20, 0), rv(20, 1), rv(20, 2), rv(20, 3), 1'b1);
        chk("clr_valid", int'(ov[0]), 0);
        for (int i = 21; i < 37; i++) begin
            send_ramp(i);
            chk("clr_prime_valid", int'(ov[0]), 0);
        end
        for (int i = 37; i < 60; i++) begin
            send_ramp(i);
            chk("clr_after_valid", int'(ov[0]), 1);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
